// File: rtl/pipelined_cla_pkg.sv
// Shared constants and stage-register layout for the pipelined carry-lookahead subtractor.
// Optional overflow tracking is selected with PIPE_SUB_OVF_EN.
package pipelined_cla_pkg;

  localparam int P_N    = 64;
  localparam int P_SEGS = 4;
  localparam int P_W    = P_N / P_SEGS;

  // One pipeline stage at default width: lower slices of dif are done, upper slices of opa/opb still pending.
  typedef struct packed {
    logic             vld;
    logic [P_N-1:0]   dif;
    logic [P_N-1:0]   opa;
    logic [P_N-1:0]   opb;
    logic             bo;
`ifdef PIPE_SUB_OVF_EN
    logic             ovf;
`endif
  } stage_t;

endpackage

// File: rtl/cla_segment.sv
// Combinational W-bit carry-lookahead adder slice built from 4-bit generate/propagate groups.
// Latency: 0 cycles. Backpressure: none (pure logic).
// Group carries chain through (G, P); carries inside a group are fully expanded.
module cla_segment
  import pipelined_cla_pkg::*;
#(
  parameter int W = P_W
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  localparam int NG = (W + 3) / 4;
  localparam int WP = NG * 4;

  logic [WP-1:0] xp, yp, g, p;
  logic [WP:0]   c;

  always_comb begin
    xp = '0;
    yp = '0;
    xp[W-1:0] = x;
    yp[W-1:0] = y;
    g = xp & yp;
    p = xp ^ yp;
    c = '0;
    c[0] = cin;
    for (int grp = 0; grp < NG; grp++) begin
      c[grp*4+1] = g[grp*4] | (p[grp*4] & c[grp*4]);
      c[grp*4+2] = g[grp*4+1] | (p[grp*4+1] & g[grp*4])
                 | (p[grp*4+1] & p[grp*4] & c[grp*4]);
      c[grp*4+3] = g[grp*4+2] | (p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+2] & p[grp*4+1] & g[grp*4])
                 | (p[grp*4+2] & p[grp*4+1] & p[grp*4] & c[grp*4]);
      // Group carry-out from group generate/propagate.
      c[grp*4+4] = (g[grp*4+3] | (p[grp*4+3] & g[grp*4+2])
                 | (p[grp*4+3] & p[grp*4+2] & g[grp*4+1])
                 | (p[grp*4+3] & p[grp*4+2] & p[grp*4+1] & g[grp*4]))
                 | (&p[grp*4 +: 4] & c[grp*4]);
    end
  end

  assign s    = p[W-1:0] ^ c[W-1:0];
  assign cout = c[W];

endmodule

// File: rtl/pipelined_cla_subtractor.sv
// Pipelined a - b - bin: one carry-lookahead segment per stage; ovf port only with PIPE_SUB_OVF_EN.
// Latency: SEGS cycles from accept edge to out_valid; throughput one beat per cycle.
// Backpressure: ready chain per stage, in_ready is combinational from out_ready; absorbs SEGS beats when stalled.
module pipelined_cla_subtractor
  import pipelined_cla_pkg::*;
#(
  parameter int N    = P_N,
  parameter int SEGS = P_SEGS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N:0]   result
`ifdef PIPE_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int W = N / SEGS;

  // Same layout as stage_t, sized by this instance's N.
  typedef struct packed {
    logic         vld;
    logic [N-1:0] dif;
    logic [N-1:0] opa;
    logic [N-1:0] opb;
    logic         bo;
`ifdef PIPE_SUB_OVF_EN
    logic         ovf;
`endif
  } stg_t;

  stg_t stg_q [SEGS];
  stg_t src   [SEGS];
  stg_t nxt   [SEGS];

  logic [SEGS:0]          rdy;
  logic [SEGS-1:0][W-1:0] seg_s;
  logic [SEGS-1:0]        seg_c;

  // Stage k consumes what stage k-1 holds; stage 0 consumes the input port.
  always_comb begin
    src[0]     = '0;
    src[0].vld = in_valid;
    src[0].opa = a;
    src[0].opb = ~b;
    src[0].bo  = bin;
    for (int k = 1; k < SEGS; k++) src[k] = stg_q[k-1];
  end

  genvar gk;
  generate
    for (gk = 0; gk < SEGS; gk++) begin : g_seg
      cla_segment #(.W(W)) u_seg (
        .x    (src[gk].opa[gk*W +: W]),
        .y    (src[gk].opb[gk*W +: W]),
        .cin  (~src[gk].bo),
        .s    (seg_s[gk]),
        .cout (seg_c[gk])
      );
    end
  endgenerate

  always_comb begin
    for (int k = 0; k < SEGS; k++) begin
      nxt[k]                = src[k];
      nxt[k].dif[k*W +: W]  = seg_s[k];
      nxt[k].bo             = ~seg_c[k];
`ifdef PIPE_SUB_OVF_EN
      // opb holds ~b, so equal top bits here mean the operand signs differ.
      nxt[k].ovf = (src[k].opa[N-1] == src[k].opb[N-1]) &&
                   (nxt[k].dif[N-1] != src[k].opa[N-1]);
`endif
    end
  end

  always_comb begin
    rdy       = '0;
    rdy[SEGS] = out_ready;
    for (int k = SEGS - 1; k >= 0; k--) rdy[k] = !stg_q[k].vld || rdy[k+1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SEGS; k++) stg_q[k] <= '0;
    end else begin
      for (int k = 0; k < SEGS; k++) begin
        if (rdy[k]) begin
          if (src[k].vld) stg_q[k]     <= nxt[k];
          else            stg_q[k].vld <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = rdy[0];
  assign out_valid = stg_q[SEGS-1].vld;
  assign result    = {stg_q[SEGS-1].bo, stg_q[SEGS-1].dif};
`ifdef PIPE_SUB_OVF_EN
  assign ovf       = stg_q[SEGS-1].ovf;
`endif

endmodule

// File: doc/pipelined_cla_subtractor.md
# pipelined_cla_subtractor

Pipelined N-bit unsigned/two's-complement subtractor computing `a - b - bin` with a carry-lookahead slice per stage and a valid/ready handshake on both sides. It mirrors the combinational carry-lookahead adder. Segmenting the carry chain across registered stages lets 64-bit subtraction close timing at full clock rate, with a throughput of one operation per cycle. It sits between operand producers (register file or testbench driver) and result consumers in the 64-bit datapath labs.

## Interface

**Parameters**

- `N`, 64: operand width.
- `SEGS`, 4: number of pipeline stages and segments; `N % SEGS == 0` is required, and the segment width is `N/SEGS`.

**Ports**

- `clk` input 1: single clock; all state changes on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat offered.
- `in_ready` output 1: stage 0 can accept.
- `a` input N: minuend.
- `b` input N: subtrahend.
- `bin` input 1: borrow in.
- `out_valid` output 1: result beat offered.
- `out_ready` input 1: consumer accepts.
- `result` output N+1: `{bout, diff}`, where `diff = (a - b - bin) mod 2^N` and `bout = 1` iff `a < b + bin` (unsigned).
- `ovf` output 1: present only with `PIPE_SUB_OVF_EN`.

## Operation

- Arithmetic: `a + ~b + c0` with `c0 = ~bin`; `bout = ~carry_out(N)`.
- Stage k (0..SEGS-1) computes segment k (bits `[k*W +: W]`) using the carry registered by stage k-1; stage 0 uses `c0`.
- Each stage register holds:
  - a valid bit,
  - the segment results produced so far (lower segments),
  - the untouched upper slices of `a` and `~b`,
  - the carry into the next segment.
- Stage handshake, with `v_k` the valid of stage k:
  - `ready_k = !v_k || ready_{k+1}`, where `ready_SEGS = out_ready`.
  - `in_ready = ready_0`.
  - A stage loads when its upstream is valid and it is ready. Otherwise it holds its contents unchanged.
- Transfers: an input is accepted on an edge with `in_valid && in_ready`. A result is consumed on an edge with `out_valid && out_ready`.
- `out_valid = v_(SEGS-1)`. `result` is driven from the last stage register and stays stable while `out_valid && !out_ready`.
- Order is strictly preserved; no beat is dropped or duplicated.
- Simultaneous consume and accept with the pipeline full: all stages shift in the same edge, sustaining full throughput.
- Boundaries:
  - `a == b` with `bin = 0` gives `result = 0`.
  - `a = 0, b = 0, bin = 1` gives `diff = all ones, bout = 1`.
  - `b = 2^N-1, bin = 1` gives a correct wrap with `bout = 1`, no special case.

## Timing

- Reset values: all valid bits 0 (so `out_valid = 0`), `result = 0`, `ovf = 0`, `in_ready = 1`.
- Reset mid-operation: all in-flight beats are discarded asynchronously. There is no output until new operands are accepted after `rst_n` deasserts.
- Latency: a beat accepted on edge t appears on `out_valid` after edge t+SEGS-1, i.e. SEGS cycles including the accept edge. This is 4 cycles at default parameters.
- Throughput: 1 beat per cycle while `out_ready = 1`.
- Ready path: `in_ready` is combinational from `out_ready` through the ready chain. There is no combinational path from `a`/`b` to `result`.
- Capacity: with `out_ready` held low, the pipeline absorbs exactly SEGS beats, then `in_ready = 0`.

## Configuration

- `PIPE_SUB_OVF_EN` defined:
  - Adds output `ovf`, the two's-complement overflow `(a[N-1] != b[N-1]) && (diff[N-1] != a[N-1])` with `bin` included in `diff`.
  - The sign bits of `a` and `b` are carried through the pipeline, and `ovf` is registered alongside `result`.
- `PIPE_SUB_OVF_EN` undefined: no `ovf` port and no sign-bit pipeline registers; `result` behaviour is identical.

## Structure

- Shared package `pipelined_cla_pkg`:
  - default `N` and `SEGS` constants,
  - the derived segment width,
  - the stage-register struct typedef (valid, partial result, remaining operands, carry).
- Sub-module `cla_segment`:
  - combinational W-bit carry-lookahead slice with 4-bit generate/propagate groups,
  - inputs `x`, `y`, `cin`; outputs `s`, `cout`.
  - It is instantiated once per stage.
- Top level contains only the stage registers and the ready chain.

## Test plan

1. **Basic differences:** `a=64, b=64, bin=0` gives `result=0`. `a=123, b=73` gives `diff=50, bout=0`, 4 cycles after accept.
2. **Negative wrap:** `a=73, b=123, bin=0` gives `diff=0xFFFF_FFFF_FFFF_FFCE, bout=1`. `a=246, b=562, bin=1` gives `diff=2^64-317, bout=1`.
3. **Back-to-back stream:** 8 back-to-back beats with `out_ready=1` (including `a=1000000000, b=1000000000`) give 8 results on consecutive cycles, in order.
4. **Backpressure:** with `out_ready=0`, 4 beats are accepted, then `in_ready=0`. The first `result` stays stable. Releasing `out_ready` drains all 4 in order with no loss.
5. **Reset mid-flight:** `rst_n` is pulsed low with 3 beats in flight. Immediately `out_valid=0` and `result=0`, with no stale beat afterwards. The first new beat arrives with full latency.
6. **Overflow (`PIPE_SUB_OVF_EN` defined):** `a=0x8000_0000_0000_0000, b=1` gives `ovf=1`. `a=5, b=7` gives `ovf=0, bout=1`.
